// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline buffer carrying an opaque payload under valid/allowin handshake.
// SKID_EN selects a single-entry register or a two-entry skid buffer with registered allowin.
module pipe_stage_buf #(
   parameter int DATA_W    = 64,
   parameter bit SKID_EN   = 1'b1,
   parameter bit FLUSH_CLR = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   input  logic              in_ready_go,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_allowin,
   output logic              in_fire,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_allowin,
   output logic [1:0]        occupancy
);

   logic              head_valid;
   logic              skid_valid;
   logic [DATA_W-1:0] head_data;
   logic              push;
   logic              pop;

   assign in_fire   = in_valid & in_ready_go & in_allowin;
   assign push      = in_fire;
   assign pop       = head_valid & out_allowin;
   assign out_valid = head_valid;
   assign out_data  = head_data;
   assign occupancy = {1'b0, head_valid} + {1'b0, skid_valid};

   generate
      if (SKID_EN) begin : g_skid
         logic [DATA_W-1:0] skid_data;

         // Allowin depends only on state, so no path from out_allowin reaches upstream.
         assign in_allowin = !skid_valid;

         always_ff @(posedge clk or posedge rst_n) begin
            if (rst_n) begin
               head_valid <= 1'b0;
               skid_valid <= 1'b0;
               head_data  <= '0;
               skid_data  <= '0;
            end else if (flush) begin
               head_valid <= 1'b0;
               skid_valid <= 1'b0;
               if (FLUSH_CLR) begin
                  head_data <= '0;
                  skid_data <= '0;
               end
            end else if (skid_valid) begin
               if (pop) begin
                  head_data  <= skid_data;
                  skid_valid <= 1'b0;
               end
            end else if (push) begin
               if (!head_valid || pop) begin
                  head_data  <= in_data;
                  head_valid <= 1'b1;
               end else begin
                  skid_data  <= in_data;
                  skid_valid <= 1'b1;
               end
            end else if (pop) begin
               head_valid <= 1'b0;
            end
         end
      end else begin : g_single
         assign in_allowin = !head_valid | out_allowin;
         assign skid_valid = 1'b0;

         always_ff @(posedge clk or posedge rst_n) begin
            if (rst_n) begin
               head_valid <= 1'b0;
               head_data  <= '0;
            end else if (flush) begin
               head_valid <= 1'b0;
               if (FLUSH_CLR) begin
                  head_data <= '0;
               end
            end else if (push) begin
               head_data  <= in_data;
               head_valid <= 1'b1;
            end else if (pop) begin
               head_valid <= 1'b0;
            end
         end
      end
   endgenerate

endmodule
